alu_share_ctrl: RTL and testbench

Two-requester controller that shares the single combinational ALU (size-bit R2/R3 operands, option select, result mux) between requesters. Round-robin arbitration with valid/ready handshakes. Drives operands and select to the ALU and holds them stable for ALU_LAT cycles. Captures the result and returns it, tagged with the requester id, on one shared response channel. Sits between the instruction/issue logic and the ALU datapath.

---
 rtl/alu_share_ctrl.sv | 155 +++++++++++++++
 tb/tb_alu_share_ctrl.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_ctrl.sv
// Round-robin controller sharing one combinational ALU between two requesters.
// Optional grant counters are enabled by defining ALU_SHARE_STATS_EN.
module alu_share_ctrl #(
  parameter int size    = 8,
  parameter int OPW     = 3,
  parameter int ALU_LAT = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [OPW-1:0]  req0_op,
  input  logic [size-1:0] req0_a,
  input  logic [size-1:0] req0_b,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [OPW-1:0]  req1_op,
  input  logic [size-1:0] req1_a,
  input  logic [size-1:0] req1_b,
  output logic [size-1:0] alu_R2,
  output logic [size-1:0] alu_R3,
  output logic [OPW-1:0]  alu_sel,
  input  logic [size-1:0] alu_result,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic            resp_id,
  output logic [size-1:0] resp_data,
  output logic            busy
`ifdef ALU_SHARE_STATS_EN
  ,
  output logic [15:0]     gnt_cnt0,
  output logic [15:0]     gnt_cnt1
`endif
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [3:0] LAT_INIT = 4'(ALU_LAT - 1);

  state_t          state_q, state_d;
  logic            last_grant_q, last_grant_d;
  logic [size-1:0] r2_q, r2_d, r3_q, r3_d;
  logic [OPW-1:0]  sel_q, sel_d;
  logic [size-1:0] resp_data_q, resp_data_d;
  logic            resp_id_q, resp_id_d;
  logic            resp_valid_q, resp_valid_d;
  logic [3:0]      lat_cnt_q, lat_cnt_d;
  logic            any_valid, grant, accept;

  always_comb begin
    any_valid    = req0_valid | req1_valid;
    // Under contention the requester that did not win last time goes first.
    grant        = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
    accept       = (state_q == IDLE) && any_valid;
    req0_ready   = accept && !grant;
    req1_ready   = accept && grant;

    state_d      = state_q;
    last_grant_d = last_grant_q;
    r2_d         = r2_q;
    r3_d         = r3_q;
    sel_d        = sel_q;
    resp_data_d  = resp_data_q;
    resp_id_d    = resp_id_q;
    resp_valid_d = resp_valid_q;
    lat_cnt_d    = lat_cnt_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          r2_d         = grant ? req1_a  : req0_a;
          r3_d         = grant ? req1_b  : req0_b;
          sel_d        = grant ? req1_op : req0_op;
          resp_id_d    = grant;
          last_grant_d = grant;
          lat_cnt_d    = LAT_INIT;
          state_d      = EXEC;
        end
      end
      EXEC: begin
        if (lat_cnt_q != '0) begin
          lat_cnt_d = lat_cnt_q - 4'd1;
        end else begin
          resp_data_d  = alu_result;
          resp_valid_d = 1'b1;
          state_d      = RESP;
        end
      end
      RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      r2_q         <= '0;
      r3_q         <= '0;
      sel_q        <= '0;
      resp_data_q  <= '0;
      resp_id_q    <= 1'b0;
      resp_valid_q <= 1'b0;
      lat_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      r2_q         <= r2_d;
      r3_q         <= r3_d;
      sel_q        <= sel_d;
      resp_data_q  <= resp_data_d;
      resp_id_q    <= resp_id_d;
      resp_valid_q <= resp_valid_d;
      lat_cnt_q    <= lat_cnt_d;
    end
  end

  assign alu_R2     = r2_q;
  assign alu_R3     = r3_q;
  assign alu_sel    = sel_q;
  assign resp_data  = resp_data_q;
  assign resp_id    = resp_id_q;
  assign resp_valid = resp_valid_q;
  assign busy       = (state_q != IDLE);

`ifdef ALU_SHARE_STATS_EN
  logic [15:0] gnt_cnt0_q, gnt_cnt0_d, gnt_cnt1_q, gnt_cnt1_d;

  always_comb begin
    gnt_cnt0_d = gnt_cnt0_q;
    gnt_cnt1_d = gnt_cnt1_q;
    if (req0_ready && gnt_cnt0_q != '1) gnt_cnt0_d = gnt_cnt0_q + 16'd1;
    if (req1_ready && gnt_cnt1_q != '1) gnt_cnt1_d = gnt_cnt1_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_cnt0_q <= '0;
      gnt_cnt1_q <= '0;
    end else begin
      gnt_cnt0_q <= gnt_cnt0_d;
      gnt_cnt1_q <= gnt_cnt1_d;
    end
  end

  assign gnt_cnt0 = gnt_cnt0_q;
  assign gnt_cnt1 = gnt_cnt1_q;
`endif

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Self-checking bench for alu_share_ctrl: two instances (ALU_LAT=1 and 4) against a
// transaction-level model; grant counters are checked when ALU_SHARE_STATS_EN is defined.
module tb_alu_share_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       v0, v1, resp_ready, tgt;
  logic [2:0] op0, op1;
  logic [7:0] a0, b0, a1, b1;

  logic       d1_rdy0, d1_rdy1, d1_rv, d1_rid, d1_busy;
  logic [7:0] d1_r2, d1_r3, d1_res, d1_rdata;
  logic [2:0] d1_sel;
  logic       d4_rdy0, d4_rdy1, d4_rv, d4_rid, d4_busy;
  logic [7:0] d4_r2, d4_r3, d4_res, d4_rdata;
  logic [2:0] d4_sel;
`ifdef ALU_SHARE_STATS_EN
  logic [15:0] g0_1, g1_1, g0_4, g1_4;
`endif

  function automatic logic [7:0] alu(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return ~a;
      3'd6: return (b > a) ? 8'd1 : 8'd0;
      default: return b;
    endcase
  endfunction

  assign d1_res = alu(d1_sel, d1_r2, d1_r3);
  assign d4_res = alu(d4_sel, d4_r2, d4_r3);

  alu_share_ctrl #(.size(8), .OPW(3), .ALU_LAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(v0 && !tgt), .req0_ready(d1_rdy0), .req0_op(op0), .req0_a(a0), .req0_b(b0),
    .req1_valid(v1 && !tgt), .req1_ready(d1_rdy1), .req1_op(op1), .req1_a(a1), .req1_b(b1),
    .alu_R2(d1_r2), .alu_R3(d1_r3), .alu_sel(d1_sel), .alu_result(d1_res),
    .resp_valid(d1_rv), .resp_ready(resp_ready), .resp_id(d1_rid), .resp_data(d1_rdata),
    .busy(d1_busy)
`ifdef ALU_SHARE_STATS_EN
    , .gnt_cnt0(g0_1), .gnt_cnt1(g1_1)
`endif
  );

  alu_share_ctrl #(.size(8), .OPW(3), .ALU_LAT(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(v0 && tgt), .req0_ready(d4_rdy0), .req0_op(op0), .req0_a(a0), .req0_b(b0),
    .req1_valid(v1 && tgt), .req1_ready(d4_rdy1), .req1_op(op1), .req1_a(a1), .req1_b(b1),
    .alu_R2(d4_r2), .alu_R3(d4_r3), .alu_sel(d4_sel), .alu_result(d4_res),
    .resp_valid(d4_rv), .resp_ready(resp_ready), .resp_id(d4_rid), .resp_data(d4_rdata),
    .busy(d4_busy)
`ifdef ALU_SHARE_STATS_EN
    , .gnt_cnt0(g0_4), .gnt_cnt1(g1_4)
`endif
  );

  // Outputs of whichever instance is currently being exercised.
  logic       o_rdy0, o_rdy1, o_rv, o_rid, o_busy;
  logic [7:0] o_r2, o_r3, o_rdata;
  logic [2:0] o_sel;
  assign o_rdy0  = tgt ? d4_rdy0  : d1_rdy0;
  assign o_rdy1  = tgt ? d4_rdy1  : d1_rdy1;
  assign o_rv    = tgt ? d4_rv    : d1_rv;
  assign o_rid   = tgt ? d4_rid   : d1_rid;
  assign o_busy  = tgt ? d4_busy  : d1_busy;
  assign o_r2    = tgt ? d4_r2    : d1_r2;
  assign o_r3    = tgt ? d4_r3    : d1_r3;
  assign o_sel   = tgt ? d4_sel   : d1_sel;
  assign o_rdata = tgt ? d4_rdata : d1_rdata;

  int nchk = 0;
  int nerr = 0;

  // Reference model: one op in flight, a countdown to its result, a pending response.
  bit         m_busy, m_rv, m_last, m_id;
  int         m_cnt;
  logic [7:0] m_a, m_b, m_data;
  logic [2:0] m_op;
  bit         acc0, acc1, obs_acc;
  int         grants[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_rv = 0; m_last = 1; m_id = 0; m_cnt = 0;
    m_a = '0; m_b = '0; m_data = '0; m_op = '0;
    acc0 = 0; acc1 = 0;
  endtask

  // Called one time unit after a rising edge with inputs already driven.
  task automatic cycle();
    bit any, g, e0, e1;
    #1;
    any = v0 | v1;
    g   = (v0 && v1) ? !m_last : v1;
    e0  = !m_busy && any && !g;
    e1  = !m_busy && any && g;
    chk("ready0", 32'(o_rdy0), 32'(e0));
    chk("ready1", 32'(o_rdy1), 32'(e1));
    chk("busy", 32'(o_busy), 32'(m_busy));
    chk("resp_valid", 32'(o_rv), 32'(m_rv));
    chk("resp_id", 32'(o_rid), 32'(m_id));
    chk("resp_data", 32'(o_rdata), 32'(m_data));
    chk("alu_R2", 32'(o_r2), 32'(m_a));
    chk("alu_R3", 32'(o_r3), 32'(m_b));
    chk("alu_sel", 32'(o_sel), 32'(m_op));
    obs_acc = (o_rdy0 && v0) || (o_rdy1 && v1);
    if (o_rdy0 && v0) grants.push_back(0);
    if (o_rdy1 && v1) grants.push_back(1);
    acc0 = e0; acc1 = e1;
    if (m_rv) begin
      if (resp_ready) begin m_rv = 0; m_busy = 0; end
    end else if (m_busy) begin
      m_cnt--;
      if (m_cnt == 0) begin m_rv = 1; m_data = alu(m_op, m_a, m_b); end
    end else if (e0 || e1) begin
      m_busy = 1; m_cnt = tgt ? 4 : 1;
      m_id = e1; m_last = e1;
      m_a = e1 ? a1 : a0; m_b = e1 ? b1 : b0; m_op = e1 ? op1 : op0;
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    v0 = 0; v1 = 0;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_busy", 32'(o_busy), 0);
    chk("rst_resp_valid", 32'(o_rv), 0);
    chk("rst_resp_data", 32'(o_rdata), 0);
    chk("rst_alu_R2", 32'(o_r2), 0);
    chk("rst_alu_sel", 32'(o_sel), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic one_op(input bit id);
    bit got = 0;
    if (id) begin v1 = 1; op1 = 3'($urandom); a1 = 8'($urandom); b1 = 8'($urandom); end
    else    begin v0 = 1; op0 = 3'($urandom); a0 = 8'($urandom); b0 = 8'($urandom); end
    for (int i = 0; i < 20 && !got; i++) begin cycle(); got = obs_acc; end
    v0 = 0; v1 = 0;
    for (int i = 0; i < 30 && o_busy; i++) cycle();
    chk("op_accepted", 32'(got), 1);
    chk("op_drained", 32'(o_busy), 0);
  endtask

  task automatic random_run(input int n);
    for (int i = 0; i < n; i++) begin
      if (!(v0 && !acc0 && $urandom_range(3) != 0)) begin
        v0 = 1'($urandom_range(1)); op0 = 3'($urandom); a0 = 8'($urandom); b0 = 8'($urandom);
      end
      if (!(v1 && !acc1 && $urandom_range(3) != 0)) begin
        v1 = 1'($urandom_range(1)); op1 = 3'($urandom); a1 = 8'($urandom); b1 = 8'($urandom);
      end
      resp_ready = ($urandom_range(3) != 0);
      cycle();
    end
    v0 = 0; v1 = 0; resp_ready = 1;
    for (int i = 0; i < 30 && o_busy; i++) cycle();
    chk("rand_drain", 32'(o_busy), 0);
  endtask

  initial begin
    tgt = 0; resp_ready = 1; v0 = 0; v1 = 0;
    op0 = '0; op1 = '0; a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    do_reset();

    // slt on the single-cycle instance: result 1 one edge after accept
    op0 = 3'd6; a0 = 8'd3; b0 = 8'd5; v0 = 1;
    cycle();
    v0 = 0;
    cycle();
    chk("slt_valid", 32'(d1_rv), 1);
    chk("slt_data", 32'(d1_rdata), 1);
    chk("slt_id", 32'(d1_rid), 0);
    cycle();

    // Contention from reset: grants alternate starting with requester 0
    do_reset();
    grants.delete();
    op0 = 3'd0; a0 = 8'h11; b0 = 8'h22; op1 = 3'd4; a1 = 8'h5A; b1 = 8'h3C;
    v0 = 1; v1 = 1;
    repeat (12) cycle();
    v0 = 0; v1 = 0;
    for (int i = 0; i < 30 && o_busy; i++) cycle();
    chk("rr_count", 32'(grants.size()), 4);
    for (int i = 0; i < 4 && i < grants.size(); i++) chk("rr_order", 32'(grants[i]), 32'(i % 2));

    // Back-pressure: response held for 10 cycles, nothing accepted
    do_reset();
    op0 = 3'd1; a0 = 8'h40; b0 = 8'h01; v0 = 1;
    cycle();
    v0 = 0;
    cycle();
    resp_ready = 0; v0 = 1; v1 = 1;
    repeat (10) cycle();
    chk("bp_data", 32'(d1_rdata), 32'h3F);
    resp_ready = 1; v0 = 0; v1 = 0;
    cycle();
    chk("bp_release", 32'(d1_busy), 0);

    // Four-cycle latency instance: operands held, no ready while busy
    do_reset();
    tgt = 1;
    op1 = 3'd6; a1 = 8'hF0; b1 = 8'h0F; v1 = 1;
    cycle();
    v1 = 0; v0 = 1; op0 = 3'd2; a0 = 8'hAA; b0 = 8'h0F;
    repeat (4) cycle();
    chk("lat4_valid", 32'(d4_rv), 1);
    chk("lat4_data", 32'(d4_rdata), 0);
    chk("lat4_id", 32'(d4_rid), 1);
    v0 = 0;
    for (int i = 0; i < 30 && o_busy; i++) cycle();

    // Reset one cycle after accept discards the op
    do_reset();
    op0 = 3'd0; a0 = 8'h12; b0 = 8'h34; v0 = 1;
    cycle();
    v0 = 0;
    cycle();
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(d4_busy), 0);
    chk("midrst_valid", 32'(d4_rv), 0);
    chk("midrst_R2", 32'(d4_r2), 0);
    chk("midrst_R3", 32'(d4_r3), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    repeat (8) cycle();

    // Randomised traffic on both instances
    do_reset();
    tgt = 0;
    random_run(400);
    do_reset();
    tgt = 1;
    random_run(300);

`ifdef ALU_SHARE_STATS_EN
    do_reset();
    tgt = 0;
    repeat (3) one_op(0);
    repeat (2) one_op(1);
    chk("gnt_cnt0", 32'(g0_1), 3);
    chk("gnt_cnt1", 32'(g1_1), 2);
    force dut1.gnt_cnt0_q = 16'hFFFF;
    #1;
    release dut1.gnt_cnt0_q;
    one_op(0);
    chk("gnt_cnt0_sat", 32'(g0_1), 32'hFFFF);
`else
    do_reset();
    tgt = 0;
    one_op(1);
`endif

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
